// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the mini CPU run controller: datapath widths, the JMP opcode
// and the controller state encoding.
package cpu_run_ctrl_pkg;

  localparam int unsigned DATA_WIDTH = 4;
  localparam int unsigned PROG_WIDTH = 8;
  localparam int unsigned OP_WIDTH   = PROG_WIDTH - DATA_WIDTH;

  localparam logic [OP_WIDTH-1:0] OP_JMP = 4'hF;

  typedef enum logic [1:0] {
    StHalt  = 2'd0,
    StRun   = 2'd1,
    StStep  = 2'd2,
    StBreak = 2'd3
  } run_state_t;

endpackage

// File: rtl/cpu_run_ctrl_btn_edge.sv
// Button conditioner: 2-FF synchronizer, stability counter, and a one-cycle pulse on each
// accepted rising level.
module btn_edge #(
  parameter int unsigned DEB = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned CntW = (DEB > 0) ? $clog2(DEB + 1) : 1;

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_prev_q;
  logic            pulse_q;
  logic [CntW-1:0] cnt_q;

  // A new level is taken only after it has differed from the accepted level for
  // DEB consecutive samples and is still different on the following one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      pulse_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= raw;
      sync2_q       <= sync1_q;
      stable_prev_q <= stable_q;
      pulse_q       <= stable_q & ~stable_prev_q;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(DEB)) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer: turns button presses, a PC breakpoint and self-jump
// detection into a single-cycle CPU clock enable on the board clock.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned DIV = 50_000_000,
  parameter int unsigned DEB = 1_000_000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  run_btn,
  input  logic                  step_btn,
  input  logic                  halt_btn,
  input  logic                  bp_en,
  input  logic [DATA_WIDTH-1:0] bp_addr,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [PROG_WIDTH-1:0] prog_data,
  output logic                  cpu_en,
  output logic [1:0]            state,
  output logic                  brk_hit,
  output logic                  idle
);

  localparam int unsigned PresW = (DIV > 1) ? $clog2(DIV) : 1;

  logic run_p, step_p, halt_p;

  btn_edge #(.DEB(DEB)) u_run_edge (
    .clk   (CLK),
    .rst   (RST),
    .raw   (run_btn),
    .pulse (run_p)
  );

  btn_edge #(.DEB(DEB)) u_step_edge (
    .clk   (CLK),
    .rst   (RST),
    .raw   (step_btn),
    .pulse (step_p)
  );

  btn_edge #(.DEB(DEB)) u_halt_edge (
    .clk   (CLK),
    .rst   (RST),
    .raw   (halt_btn),
    .pulse (halt_p)
  );

  run_state_t       state_q, state_d;
  logic [PresW-1:0] presc_q, presc_d;
  logic             skip_q, skip_d;
  logic             idle_q, idle_d;
  logic             en_q, en_d;
  logic             brk_q, brk_d;

  logic at_tc, bp_match, self_jmp;

  assign at_tc    = (presc_q == PresW'(DIV - 1));
  // skip lets a resume from BREAK execute the breakpointed instruction once.
  assign bp_match = !skip_q && bp_en && (pc == bp_addr);
  assign self_jmp = (prog_data[PROG_WIDTH-1 -: OP_WIDTH] == OP_JMP) &&
                    (prog_data[DATA_WIDTH-1:0] == pc);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    skip_d  = skip_q;
    idle_d  = idle_q;
    en_d    = 1'b0;

    unique case (state_q)
      StHalt, StBreak: begin
        if (halt_p) begin
          state_d = StHalt;
        end else if (step_p) begin
          state_d = StStep;
          en_d    = 1'b1;
        end else if (run_p) begin
          state_d = StRun;
          presc_d = '0;
          skip_d  = 1'b1;
        end
      end
      StStep: begin
        state_d = StHalt;
      end
      StRun: begin
        if (halt_p) begin
          state_d = StHalt;
        end else if (at_tc) begin
          presc_d = '0;
          if (bp_match) begin
            state_d = StBreak;
          end else if (self_jmp) begin
            state_d = StHalt;
            idle_d  = 1'b1;
          end else begin
            en_d   = 1'b1;
            skip_d = 1'b0;
          end
        end else begin
          presc_d = presc_q + PresW'(1);
        end
      end
    endcase

    if (state_d != StHalt) begin
      idle_d = 1'b0;
    end
    brk_d = (state_d == StBreak);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StHalt;
      presc_q <= '0;
      skip_q  <= 1'b0;
      idle_q  <= 1'b0;
      en_q    <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      skip_q  <= skip_d;
      idle_q  <= idle_d;
      en_q    <= en_d;
      brk_q   <= brk_d;
    end
  end

  assign cpu_en  = en_q;
  assign state   = state_q;
  assign brk_hit = brk_q;
  assign idle    = idle_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios with hand-computed cycle numbers plus a long
// randomized run, all checked every cycle against a timeline-based behavioural model.
module tb_cpu_run_ctrl;
  import cpu_run_ctrl_pkg::*;

  localparam int unsigned DIV = 8;
  localparam int unsigned DEB = 4;
  localparam int OFF  = 16;
  localparam int MAXC = 20000;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       run_btn = 1'b0, step_btn = 1'b0, halt_btn = 1'b0, bp_en = 1'b0;
  logic [3:0] bp_addr = 4'd0, pc = 4'd0;
  logic [7:0] prog_data = 8'd0;
  logic       cpu_en, brk_hit, idle;
  logic [1:0] state;

  cpu_run_ctrl #(.DIV(DIV), .DEB(DEB)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .run_btn   (run_btn),
    .step_btn  (step_btn),
    .halt_btn  (halt_btn),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .pc        (pc),
    .prog_data (prog_data),
    .cpu_en    (cpu_en),
    .state     (state),
    .brk_hit   (brk_hit),
    .idle      (idle)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = -1;

  // Model: state as an integer, next evaluation edge as an absolute cycle number,
  // button pulses from the raw-sample history.
  int  m_state = 0;
  bit  m_en = 0, m_brk = 0, m_idle = 0, m_skip = 0;
  int  next_eval = 0;
  bit  hist[3][MAXC];
  bit  acc[3];
  int  rise_at[3];
  bit  mp[3];

  int         en_log[$];
  logic [3:0] pc_log[$];
  bit         pc_auto = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    bit raw[3];
    int idx;
    int nst;
    bit en;
    bit flip;
    raw[0] = run_btn;
    raw[1] = step_btn;
    raw[2] = halt_btn;
    idx = cyc + OFF;
    if (RST) begin
      m_state = 0; m_en = 0; m_brk = 0; m_idle = 0; m_skip = 0;
      for (int b = 0; b < 3; b++) begin
        hist[b][idx] = 0;
        hist[b][idx-1] = 0;
        acc[b] = 0;
        rise_at[b] = -100;
        mp[b] = 0;
      end
      return;
    end
    for (int b = 0; b < 3; b++) hist[b][idx] = raw[b];

    nst = m_state;
    en  = 0;
    if (m_state == 0 || m_state == 3) begin
      if (mp[2]) nst = 0;
      else if (mp[1]) begin nst = 2; en = 1; end
      else if (mp[0]) begin nst = 1; m_skip = 1; next_eval = cyc + int'(DIV); end
    end else if (m_state == 2) begin
      nst = 0;
    end else begin
      if (mp[2]) nst = 0;
      else if (cyc == next_eval) begin
        next_eval += int'(DIV);
        if (!m_skip && bp_en && pc == bp_addr) nst = 3;
        else if (prog_data[7:4] == 4'hF && prog_data[3:0] == pc) begin nst = 0; m_idle = 1; end
        else begin en = 1; m_skip = 0; end
      end
    end
    if (nst != 0) m_idle = 0;
    m_state = nst;
    m_en    = en;
    m_brk   = (nst == 3);

    // Synced sample at edge t is the raw level from edge t-2; DEB+1 differing samples flip it.
    for (int b = 0; b < 3; b++) begin
      flip = 1;
      for (int k = 0; k <= int'(DEB); k++)
        if (hist[b][idx-2-k] == acc[b]) flip = 0;
      if (flip) begin
        acc[b] = ~acc[b];
        if (acc[b]) rise_at[b] = cyc;
      end
      mp[b] = (rise_at[b] == cyc - 1);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    model_step();
    check("state", int'(state), m_state);
    check("cpu_en", int'(cpu_en), int'(m_en));
    check("brk_hit", int'(brk_hit), int'(m_brk));
    check("idle", int'(idle), int'(m_idle));
    if (cpu_en) begin
      en_log.push_back(cyc);
      pc_log.push_back(pc);
      if (pc_auto) pc = pc + 4'd1;
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    run_btn = 1'b0; step_btn = 1'b0; halt_btn = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    en_log.delete();
    pc_log.delete();
  endtask

  function automatic int en_at(input int i, input int base);
    if (i < en_log.size()) return en_log[i] - base;
    return -1;
  endfunction

  function automatic int last_pc();
    if (pc_log.size() > 0) return int'(pc_log[pc_log.size()-1]);
    return -1;
  endfunction

  int  s0, n, r0, m, t0, g0;
  int  st_max, idle_seen;
  int  hold[3];
  bit  lvl[3];

  initial begin
    // Reset then quiet.
    do_reset();
    st_max = 0; idle_seen = 0;
    repeat (50) begin
      tick();
      if (int'(state) > st_max) st_max = int'(state);
      if (idle) idle_seen = 1;
    end
    check("a_no_enable", en_log.size(), 0);
    check("a_state_halt", st_max, 0);
    check("a_idle_low", idle_seen, 0);

    // Step button held from s0: pulse at s0+7, STEP with enable at s0+8.
    do_reset();
    s0 = cyc + 1;
    step_btn = 1'b1;
    run_to(s0 + 7);
    check("b_before_step", int'(state), 0);
    run_to(s0 + 8);
    check("b_step_state", int'(state), 2);
    check("b_step_en", int'(cpu_en), 1);
    run_to(s0 + 9);
    check("b_back_halt", int'(state), 0);
    run_to(s0 + 40);
    check("b_one_enable", en_log.size(), 1);
    check("b_enable_cycle", en_at(0, s0), 8);
    step_btn = 1'b0;

    // Run: pulse at n, enables at n+9, n+17, n+25.
    do_reset();
    pc = 4'd0; pc_auto = 1; prog_data = 8'h00; bp_en = 1'b0;
    s0 = cyc + 1; n = s0 + 7;
    run_btn = 1'b1;
    run_to(n + 30);
    check("c_en_count", en_log.size(), 3);
    check("c_en0", en_at(0, n), 9);
    check("c_en1", en_at(1, n), 17);
    check("c_en2", en_at(2, n), 25);
    check("c_running", int'(state), 1);

    // Same, with a halt pulse at n+16 cancelling the n+17 enable.
    do_reset();
    pc = 4'd0;
    s0 = cyc + 1; n = s0 + 7;
    run_btn = 1'b1;
    run_to(s0 + 15);
    halt_btn = 1'b1;
    run_to(n + 16);
    check("c2_still_run", int'(state), 1);
    run_to(n + 17);
    check("c2_halted", int'(state), 0);
    check("c2_no_en_tc", int'(cpu_en), 0);
    run_to(n + 40);
    check("c2_en_count", en_log.size(), 1);
    check("c2_en0", en_at(0, n), 9);
    halt_btn = 1'b0;

    // Breakpoint at pc=3, then resume executes pc=3 once.
    do_reset();
    pc = 4'd0; pc_auto = 1; bp_en = 1'b1; bp_addr = 4'd3; prog_data = 8'h00;
    s0 = cyc + 1; n = s0 + 7;
    run_btn = 1'b1;
    run_to(n + 2);
    run_btn = 1'b0;
    run_to(n + 33);
    check("d_brk_state", int'(state), 3);
    check("d_brk_hit", int'(brk_hit), 1);
    check("d_brk_no_en", int'(cpu_en), 0);
    check("d_en_before", en_log.size(), 3);
    run_to(n + 45);
    check("d_still_brk", int'(state), 3);
    r0 = cyc + 1; m = r0 + 7;
    run_btn = 1'b1;
    run_to(m + 9);
    check("d_resume_en", int'(cpu_en), 1);
    check("d_resume_pc", last_pc(), 3);
    run_to(m + 17);
    check("d_next_en", int'(cpu_en), 1);
    check("d_next_pc", last_pc(), 4);
    check("d_run_state", int'(state), 1);
    run_btn = 1'b0;
    bp_en = 1'b0;

    // Self-jump at pc=5 halts with idle; a step clears idle and executes once.
    do_reset();
    pc_auto = 0; pc = 4'd5; prog_data = 8'hF5;
    s0 = cyc + 1; n = s0 + 7;
    run_btn = 1'b1;
    run_to(n + 2);
    run_btn = 1'b0;
    run_to(n + 8);
    check("e_run_state", int'(state), 1);
    run_to(n + 9);
    check("e_idle_halt", int'(state), 0);
    check("e_idle_set", int'(idle), 1);
    check("e_idle_no_en", int'(cpu_en), 0);
    run_to(n + 30);
    check("e_no_enables", en_log.size(), 0);
    t0 = cyc + 1;
    step_btn = 1'b1;
    run_to(t0 + 8);
    check("e_step_state", int'(state), 2);
    check("e_step_en", int'(cpu_en), 1);
    check("e_idle_clear", int'(idle), 0);
    run_to(t0 + 20);
    check("e_en_total", en_log.size(), 1);
    step_btn = 1'b0;

    // Halt and step together in HALT; then a 3-cycle halt glitch while running.
    do_reset();
    pc = 4'd0; pc_auto = 1; prog_data = 8'h00;
    s0 = cyc + 1;
    halt_btn = 1'b1; step_btn = 1'b1;
    run_to(s0 + 30);
    check("f_halt_wins", int'(state), 0);
    check("f_no_en", en_log.size(), 0);
    halt_btn = 1'b0; step_btn = 1'b0;
    run_to(cyc + 12);
    en_log.delete();
    s0 = cyc + 1; n = s0 + 7;
    run_btn = 1'b1;
    run_to(n + 12);
    g0 = cyc + 1;
    halt_btn = 1'b1;
    run_to(g0 + 2);
    halt_btn = 1'b0;
    run_to(g0 + 40);
    check("f_glitch_state", int'(state), 1);
    check("f_glitch_ens", en_log.size(), 6);
    run_btn = 1'b0;

    // Randomized traffic.
    for (int b = 0; b < 3; b++) begin hold[b] = 0; lvl[b] = 0; end
    pc_auto = 1;
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          lvl[b]  = (b == 2) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1);
          hold[b] = $urandom_range(1, 25);
        end
        hold[b]--;
      end
      run_btn  = lvl[0];
      step_btn = lvl[1];
      halt_btn = lvl[2];
      RST      = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 39) == 0) pc = 4'($urandom);
      if ($urandom_range(0, 59) == 0) bp_en = ~bp_en;
      if ($urandom_range(0, 59) == 0) bp_addr = 4'($urandom);
      prog_data = ($urandom_range(0, 4) == 0) ? {4'hF, pc} : 8'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step/breakpoint sequencer for the 4-bit mini CPU. It replaces the free-running 1 Hz divided clock with a single-cycle clock enable, `cpu_en`, on the board clock. All CPU state elements (A, B, C, PC, carry flag) load only when `cpu_en` is high. Three push-buttons plus a PC breakpoint let the board run, halt, single-step, and stop on an idle self-jump loop.

## Interface
Parameters:
- `DIV`, default 50_000_000. CLK cycles between enables in RUN. Must be ≥ 2.
- `DEB`, default 1_000_000. Consecutive stable samples required to accept a button level. Must be ≥ 1.

Ports:
- `CLK` in 1: board clock; the only clock.
- `RST` in 1: synchronous, active-high reset.
- `run_btn`, `step_btn`, `halt_btn` in 1 each: raw asynchronous buttons, active-high.
- `bp_en` in 1: breakpoint enable (slide switch, level).
- `bp_addr` in `DATA_WIDTH` (4): breakpoint PC value.
- `pc` in `DATA_WIDTH`: current PC value.
- `prog_data` in `PROG_WIDTH` (8): instruction at `pc`, from ROM.
- `cpu_en` out 1: registered; high for exactly one CLK cycle per executed instruction.
- `state` out 2: current controller state (encoding below).
- `brk_hit` out 1: registered; high while `state` is BREAK.
- `idle` out 1: registered; high while `state` is HALT because a self-jump was detected.

## Operation
- Each button passes through its own `btn_edge` instance, which produces a one-cycle pulse on each accepted rising edge. The resulting pulses are `run_p`, `step_p`, `halt_p`.
- States: HALT=0, RUN=1, STEP=2, BREAK=3. Reset state is HALT.
- Same-cycle pulse priority: `halt_p` > `step_p` > `run_p`.
- HALT or BREAK:
  - `step_p` → STEP.
  - `run_p` → RUN, with the prescaler cleared to 0 and the `skip` flag set.
- STEP: `cpu_en` is high this cycle. Next state is HALT. No other pulse is sampled while in STEP.
- RUN:
  - The prescaler counts 0..DIV-1 and wraps.
  - At terminal count (TC = DIV-1), the controller first evaluates the current instruction:
    - If `skip`=0, `bp_en`=1 and `pc`==`bp_addr`: go to BREAK and emit no enable.
    - Otherwise, if `prog_data[7:4]`==4'hF and `prog_data[3:0]`==`pc` (JMP to itself): go to HALT, set `idle`, emit no enable.
    - Otherwise: assert `cpu_en` next cycle and clear `skip`.
  - `halt_p` in any RUN cycle → HALT. No enable is issued, even if it coincides with TC.
- `skip` guarantees that resuming from BREAK executes the breakpointed instruction once.
- The idle check is not subject to `skip`.
- `idle` clears on any transition out of HALT.
- STEP never checks the breakpoint or the idle loop.
- `step_p` and `run_p` arriving while in RUN are ignored.

## Timing
- Reset values: `state`=HALT, `cpu_en`=0, `brk_hit`=0, `idle`=0, prescaler=0, `skip`=0, debouncers at stable-low with counters 0.
- `btn_edge` pipeline:
  - 2-FF synchronizer, then a stability counter.
  - A raw level that is stable from edge 0 yields the pulse at edge DEB+3.
  - The pulse is high for one cycle per press.
  - A level held high never re-pulses. A glitch shorter than DEB samples is rejected.
- Pulse at cycle N in HALT or BREAK:
  - `step_p`: `state`=STEP and `cpu_en`=1 during N+1; `state`=HALT at N+2.
  - `run_p`: `state`=RUN at N+1; first `cpu_en` at N+DIV+1, then every DIV cycles.
- BREAK or idle-HALT entry: `state` updates at TC+1. `cpu_en` stays 0.
- `halt_p` at cycle N in RUN: `state`=HALT at N+1; `cpu_en`=0 from N+1 onward.
- `RST` takes priority over everything. Asserting it mid-RUN forces all reset values at the next edge. Any enable that was pending is dropped.

## Structure
- State encoding `run_state_t` goes in the shared package, alongside the existing `DATA_WIDTH`/`PROG_WIDTH` definitions in `def.svh`.
- Also place the JMP opcode constant `OP_JMP` = 4'hF there.
- One sub-module, `btn_edge` (parameter `DEB`), instantiated three times.
- Top-level integration: replace `slow_clk` with this block. Feed `cpu_en` to the `ld` gating of the registers, the counter, and the carry flop. Everything runs on `CLK`.

## Test plan
All scenarios use `DIV`=8, `DEB`=4.
- Reset, then idle for 50 cycles → `state`=0, `cpu_en` never high, `idle`=0.
- `step_btn` stable high from cycle 0 → one `cpu_en` at cycle 8. `state`=2 at cycle 8 and 0 at cycle 9. Holding the button produces no further enables.
- `run_p` at cycle N, program `pc` 0→1→2 → `cpu_en` at N+9, N+17, N+25. A `halt_p` at N+16 leaves only the N+9 enable.
- `bp_en`=1, `bp_addr`=3 while running → BREAK entered at the TC with `pc`=3, `brk_hit`=1, no enable. A subsequent `run_p` yields an enable at the next TC with `pc` still 3, then normal running.
- `prog_data`=8'hF5 with `pc`=5 in RUN → HALT at TC+1, `idle`=1, no enable. A later `step_p` clears `idle` and gives one enable.
- `halt_p` and `step_p` in the same cycle while in HALT → HALT wins, no enable. A `halt_btn` glitch lasting 3 cycles → no pulse.
